// File: rtl/fa_sub_serial.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// LSB first, with a start/done handshake. Results match the parallel add/sub unit.
module fa_sub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    count;

  // Full-adder cell on the current LSBs.
  logic s_bit_c;
  logic carry_nxt_c;
  assign s_bit_c     = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Control FSM and datapath; the final bit and result commit share one edge,
  // so the carry into the MSB is the live carry register at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      S      <= '0;
      Cout   <= 1'b0;
      V      <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B ^ {WIDTH{Sub}};
            carry <= Sub;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= carry_nxt_c;
          res_sh <= {s_bit_c, res_sh[WIDTH-1:1]};
          count  <= count + CW'(1);
          if (count == LAST) begin
            S     <= {s_bit_c, res_sh[WIDTH-1:1]};
            Cout  <= carry_nxt_c;
            V     <= carry ^ carry_nxt_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_sub_serial.sv
// Self-checking bench for fa_sub_serial: directed vectors, handshake corner cases,
// reset abort, and random operations against an arithmetic reference model.
module tb_fa_sub_serial;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Sub;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;

  int checks = 0;
  int errors = 0;

  fa_sub_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Sub  (Sub),
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout),
    .V    (V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic, returns {V, Cout, S}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic         v;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
    v   = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return {v, sum[W], sum[W-1:0]};
  endfunction

  // Called at a negedge: presents the operands with start high for one edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    A = a; B = b; Sub = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", 32'(busy), 32'd1);
    chk("done_low_on_start", 32'(done), 32'd0);
  endtask

  // Waits for done (bounded), checks latency, hold of old results, and new results.
  task automatic finish(input logic [W+1:0] exp, input bit garbage);
    logic [W+1:0] prev;
    int k;
    bit held;
    prev = {V, Cout, S};
    held = 1'b1;
    k = 1;
    while (!done && k < 20) begin
      if (garbage && (k == 3 || k == 4)) begin
        start = 1'b1; A = W'($urandom); B = W'($urandom); Sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (!done && (busy !== 1'b1 || {V, Cout, S} !== prev)) held = 1'b0;
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'd9);
    chk("busy_hold_results_stable", 32'(held), 32'd1);
    chk("result_S", 32'(S), 32'(exp[W-1:0]));
    chk("result_Cout", 32'(Cout), 32'(exp[W]));
    chk("result_V", 32'(V), 32'(exp[W+1]));
    chk("busy_off_at_done", 32'(busy), 32'd0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                    input logic [W+1:0] exp, input bit garbage);
    @(negedge clk);
    launch(a, b, sub);
    finish(exp, garbage);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    bit           seen_done;

    // Reset with start held high: nothing may start.
    rst = 1'b1; start = 1'b1; A = 8'h11; B = 8'h22; Sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_V", 32'(V), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Directed arithmetic vectors, expectations written out by hand.
    op(8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h08}, 1'b0);
    op(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, 1'b0);
    op(8'h05, 8'h03, 1'b1, {1'b0, 1'b1, 8'h02}, 1'b0);
    op(8'h03, 8'h05, 1'b1, {1'b0, 1'b0, 8'hFE}, 1'b0);
    op(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, 1'b0);
    op(8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F}, 1'b0);

    // Mid-operation start pulses and operand changes are ignored.
    op(8'h40, 8'h30, 1'b0, {1'b0, 1'b0, 8'h70}, 1'b1);

    // Back-to-back: start in the done cycle, second done 9 edges later.
    op(8'h10, 8'h20, 1'b1, {1'b0, 1'b0, 8'hF0}, 1'b0);
    launch(8'h33, 8'h11, 1'b0);
    finish({1'b0, 1'b0, 8'h44}, 1'b0);

    // Reset during bit 4 aborts with no done and cleared results.
    @(negedge clk);
    launch(8'h7F, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_SCV", 32'({V, Cout, S}), 32'd0);
    seen_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    op(8'h02, 8'h02, 1'b0, {1'b0, 1'b0, 8'h04}, 1'b0);

    // Random operations against the model, with random garbage and back-to-back.
    @(negedge clk);
    ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
    launch(ra, rb, rs);
    for (int i = 0; i < 30; i++) begin
      finish(model(ra, rb, rs), 1'($urandom));
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      launch(ra, rb, rs);
    end
    finish(model(ra, rb, rs), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
